// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bus of the integer register file scoreboard.
// The master modport is the pipeline side; the slave modport is the register file.
interface regfile_scoreboard_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRD   = 2
);
   localparam int AW = $clog2(NREGS);

   logic [NRD*AW-1:0]   RD_ADRS;
   logic [NRD*XLEN-1:0] RD_DATA;
   logic [NRD-1:0]      RD_BUSY;
   logic                WB0_EN;
   logic [AW-1:0]       WB0_ADDRESS;
   logic [XLEN-1:0]     WB0_DATA;
   logic                WB1_EN;
   logic [AW-1:0]       WB1_ADDRESS;
   logic [XLEN-1:0]     WB1_DATA;
   logic                ISSUE_EN;
   logic [AW-1:0]       ISSUE_ADDRESS;
   logic                FLUSH;
   logic [AW:0]         BUSY_COUNT;

   modport master (
      output RD_ADRS, WB0_EN, WB0_ADDRESS, WB0_DATA, WB1_EN, WB1_ADDRESS, WB1_DATA,
             ISSUE_EN, ISSUE_ADDRESS, FLUSH,
      input  RD_DATA, RD_BUSY, BUSY_COUNT
   );

   modport slave (
      input  RD_ADRS, WB0_EN, WB0_ADDRESS, WB0_DATA, WB1_EN, WB1_ADDRESS, WB1_DATA,
             ISSUE_EN, ISSUE_ADDRESS, FLUSH,
      output RD_DATA, RD_BUSY, BUSY_COUNT
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file with two writeback ports, x0 tied to zero and a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_scoreboard #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRD   = 2
) (
   input  logic                 CLK,
   input  logic                 RESET,
   regfile_scoreboard_if.slave  bus
);
   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0]     regs_r [NREGS];
   logic [NREGS-1:0]    busy_r;
   logic [NREGS-1:0]    busy_nxt_s;
   logic [AW:0]         busy_count_r;
   logic [AW-1:0]       rd_addr_s [NRD];
   logic [NRD*XLEN-1:0] rd_data_s;
   logic [NRD-1:0]      rd_busy_s;
   logic                wb0_wr_s;
   logic                wb1_wr_s;

   function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
      logic [AW:0] n;
      n = {(AW+1){1'b0}};
      for (int i = 0; i < NREGS; i++) begin
         n = n + {{AW{1'b0}}, v[i]};
      end
      return n;
   endfunction

   assign wb0_wr_s = bus.WB0_EN && (bus.WB0_ADDRESS != {AW{1'b0}});
   assign wb1_wr_s = bus.WB1_EN && (bus.WB1_ADDRESS != {AW{1'b0}});

   // Scoreboard next state: flush, then issue (new owner), then writeback clear, then hold.
   always_comb begin
      busy_nxt_s = busy_r;
      for (int r = 1; r < NREGS; r++) begin
         if (bus.FLUSH) begin
            busy_nxt_s[r] = 1'b0;
         end else if (bus.ISSUE_EN && (bus.ISSUE_ADDRESS == AW'(r))) begin
            busy_nxt_s[r] = 1'b1;
         end else if ((bus.WB0_EN && (bus.WB0_ADDRESS == AW'(r))) ||
                      (bus.WB1_EN && (bus.WB1_ADDRESS == AW'(r)))) begin
            busy_nxt_s[r] = 1'b0;
         end else begin
            busy_nxt_s[r] = busy_r[r];
         end
      end
      busy_nxt_s[0] = 1'b0;
   end

   // Register storage; WB1 is applied last so it wins a same-address collision.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_r[i] <= {XLEN{1'b0}};
         end
      end else begin
         if (wb0_wr_s) begin
            regs_r[bus.WB0_ADDRESS] <= bus.WB0_DATA;
         end
         if (wb1_wr_s) begin
            regs_r[bus.WB1_ADDRESS] <= bus.WB1_DATA;
         end
      end
   end

   // Busy bits and their count move together so the count never lags the scoreboard.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         busy_r       <= {NREGS{1'b0}};
         busy_count_r <= {(AW+1){1'b0}};
      end else begin
         busy_r       <= busy_nxt_s;
         busy_count_r <= popcount(busy_nxt_s);
      end
   end

   // Split the packed read address bus into per-port addresses.
   always_comb begin
      for (int k = 0; k < NRD; k++) begin
         rd_addr_s[k] = bus.RD_ADRS[k*AW +: AW];
      end
   end

   // Combinational read ports; forwarding is held off during RESET so outputs read zero.
   always_comb begin
      rd_data_s = {(NRD*XLEN){1'b0}};
      rd_busy_s = {NRD{1'b0}};
      for (int k = 0; k < NRD; k++) begin
         if (rd_addr_s[k] == {AW{1'b0}}) begin
            rd_data_s[k*XLEN +: XLEN] = {XLEN{1'b0}};
            rd_busy_s[k]              = 1'b0;
         end else begin
`ifdef REGFILE_BYPASS_EN
            if (!RESET && wb1_wr_s && (bus.WB1_ADDRESS == rd_addr_s[k])) begin
               rd_data_s[k*XLEN +: XLEN] = bus.WB1_DATA;
               rd_busy_s[k]              = bus.ISSUE_EN && (bus.ISSUE_ADDRESS == rd_addr_s[k]);
            end else if (!RESET && wb0_wr_s && (bus.WB0_ADDRESS == rd_addr_s[k])) begin
               rd_data_s[k*XLEN +: XLEN] = bus.WB0_DATA;
               rd_busy_s[k]              = bus.ISSUE_EN && (bus.ISSUE_ADDRESS == rd_addr_s[k]);
            end else begin
               rd_data_s[k*XLEN +: XLEN] = regs_r[rd_addr_s[k]];
               rd_busy_s[k]              = busy_r[rd_addr_s[k]];
            end
`else
            rd_data_s[k*XLEN +: XLEN] = regs_r[rd_addr_s[k]];
            rd_busy_s[k]              = busy_r[rd_addr_s[k]];
`endif
         end
      end
   end

   assign bus.RD_DATA    = rd_data_s;
   assign bus.RD_BUSY    = rd_busy_s;
   assign bus.BUSY_COUNT = busy_count_r;
endmodule
